// File: rtl/garduino_pwm_lights_if.sv
// Avalon-MM slave bus bundle for the garduino PWM lights peripheral.
// The host drives the request signals, and the peripheral returns zero-wait-state read data.
interface garduino_pwm_lights_if;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/garduino_pwm_lights.sv
// Bank of dimmable light channels with per-channel enable and PWM duty.
// Duty writes are shadowed and only take effect on a PWM period boundary.
module garduino_pwm_lights #(
  parameter int unsigned CHANNELS = 9,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  garduino_pwm_lights_if.slave  bus,
  output logic [CHANNELS-1:0]   out_port
);

  // Last counter value before wrap: PER-1 = 2^CNT_W - 2.
  localparam logic [CNT_W-1:0] CntLast = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [CHANNELS-1:0] outen_q, outen_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic [CNT_W-1:0]    shadow_q [CHANNELS];
  logic [CNT_W-1:0]    shadow_d [CHANNELS];
  logic [CNT_W-1:0]    active_q [CHANNELS];
  logic [CNT_W-1:0]    active_d [CHANNELS];
  logic [CHANNELS-1:0] out_q, out_d;

  logic        wr_en, tick, wrap_evt, duty_sel;
  logic [3:0]  duty_idx;
  logic [31:0] rdata;
  logic        unused_wdata;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign duty_sel = bus.address[4];
  assign duty_idx = bus.address[3:0];
  assign tick     = (pcnt_q == presc_q);
  assign wrap_evt = tick && (cnt_q == CntLast);
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    outen_d = outen_q;
    presc_d = presc_q;
    wrap_d  = wrap_q;
    pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick) cnt_d = wrap_evt ? '0 : cnt_q + 1'b1;

    if (wr_en) begin
      case (bus.address)
        5'h00: outen_d = bus.writedata[CHANNELS-1:0];
        5'h01: outen_d = outen_q | bus.writedata[CHANNELS-1:0];
        5'h02: outen_d = outen_q & ~bus.writedata[CHANNELS-1:0];
        5'h03: begin
          presc_d = bus.writedata[PRESC_W-1:0];
          pcnt_d  = '0;
        end
        5'h04: if (bus.writedata[0]) wrap_d = 1'b0;
        default: ;
      endcase
    end
    // A wrap on the same cycle as a W1C leaves WRAP set.
    if (wrap_evt) wrap_d = 1'b1;

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      shadow_d[k] = shadow_q[k];
      if (wr_en && duty_sel && (duty_idx == 4'(k))) shadow_d[k] = bus.writedata[CNT_W-1:0];
      // Loading from shadow_d lets a write on the wrap cycle take effect immediately.
      active_d[k] = wrap_evt ? shadow_d[k] : active_q[k];
      out_d[k]    = outen_q[k] & (cnt_q < active_q[k]);
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      5'h00, 5'h01, 5'h02: rdata[CHANNELS-1:0] = outen_q;
      5'h03:               rdata[PRESC_W-1:0]  = presc_q;
      5'h04:               rdata[0]            = wrap_q;
      default: ;
    endcase
    if (duty_sel) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (duty_idx == 4'(k)) rdata = 32'(shadow_q[k]);
      end
    end
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      outen_q <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      outen_q <= outen_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

endmodule

// File: tb/tb_garduino_pwm_lights.sv
// Directed bench for garduino_pwm_lights: a register-access vector table plus
// hand-written PWM timing, duty shadowing, prescaler and reset sequences.
module tb_garduino_pwm_lights;

  localparam int Limit = 5000;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] out_port;
  int         n_chk = 0;
  int         n_fail = 0;

  garduino_pwm_lights_if bus ();

  garduino_pwm_lights #(
    .CHANNELS (9),
    .CNT_W    (8),
    .PRESC_W  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    data           = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Counts negedges until out_port[ch] goes 0 -> 1.
  task automatic wait_rise(input int ch, input string name, output int n);
    logic prev;
    logic found;
    n     = 0;
    found = 1'b0;
    while (!found && n < Limit) begin
      prev = out_port[ch];
      @(negedge clk);
      n++;
      if (!prev && out_port[ch]) found = 1'b1;
    end
    chk({name, "_rise_seen"}, 32'(found), 32'd1);
  endtask

  // Counts negedges for which out_port[ch] stays at lvl; starts at the current negedge.
  task automatic measure_run(input int ch, input logic lvl, output int len);
    len = 0;
    while (out_port[ch] === lvl && len < Limit) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  zaddr [6];
    int          h, l, n, bad0, bad1, bad2;

    vecs[0]  = '{1'b1, 5'h01, 32'h0000_0005};
    vecs[1]  = '{1'b0, 5'h00, 32'h0000_0005};
    vecs[2]  = '{1'b1, 5'h02, 32'h0000_0001};
    vecs[3]  = '{1'b0, 5'h00, 32'h0000_0004};
    vecs[4]  = '{1'b0, 5'h01, 32'h0000_0004};
    vecs[5]  = '{1'b0, 5'h02, 32'h0000_0004};
    vecs[6]  = '{1'b1, 5'h00, 32'hFFFF_FFFF};
    vecs[7]  = '{1'b0, 5'h00, 32'h0000_01FF};
    vecs[8]  = '{1'b1, 5'h02, 32'h0000_01F0};
    vecs[9]  = '{1'b0, 5'h00, 32'h0000_000F};
    vecs[10] = '{1'b1, 5'h00, 32'h0000_0000};
    vecs[11] = '{1'b0, 5'h00, 32'h0000_0000};
    vecs[12] = '{1'b1, 5'h1F, 32'h0000_00AB};
    vecs[13] = '{1'b0, 5'h1F, 32'h0000_0000};
    vecs[14] = '{1'b1, 5'h19, 32'h0000_0055};
    vecs[15] = '{1'b0, 5'h19, 32'h0000_0000};
    vecs[16] = '{1'b1, 5'h18, 32'h0000_01FF};
    vecs[17] = '{1'b0, 5'h18, 32'h0000_00FF};
    vecs[18] = '{1'b1, 5'h05, 32'h0000_0123};
    vecs[19] = '{1'b0, 5'h05, 32'h0000_0000};
    vecs[20] = '{1'b1, 5'h03, 32'h0001_2345};
    vecs[21] = '{1'b0, 5'h03, 32'h0000_2345};
    vecs[22] = '{1'b1, 5'h03, 32'h0000_0000};
    vecs[23] = '{1'b0, 5'h03, 32'h0000_0000};
    vecs[24] = '{1'b1, 5'h18, 32'h0000_0000};
    vecs[25] = '{1'b0, 5'h18, 32'h0000_0000};

    zaddr[0] = 5'h00; zaddr[1] = 5'h01; zaddr[2] = 5'h02;
    zaddr[3] = 5'h03; zaddr[4] = 5'h04; zaddr[5] = 5'h10;

    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < 6; i++) begin
      rd(zaddr[i], d);
      chk($sformatf("reset_rd_%02h", zaddr[i]), d, 32'd0);
    end
    bad0 = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_port !== 9'd0) bad0++;
    end
    chk("reset_out_low_100", 32'(bad0), 32'd0);

    // Register access table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, d);
        chk($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), d, vecs[i].data);
      end
    end

    // Duty 64 at PRESC 0: 64 high, 191 low
    wr(5'h10, 32'd64);
    wr(5'h00, 32'h1);
    wait_rise(0, "duty64", n);
    measure_run(0, 1'b1, h);
    chk("duty64_high", 32'(h), 32'd64);
    measure_run(0, 1'b0, l);
    chk("duty64_low", 32'(l), 32'd191);
    measure_run(0, 1'b1, h);
    chk("duty64_high_rep", 32'(h), 32'd64);
    measure_run(0, 1'b0, l);
    chk("duty64_low_rep", 32'(l), 32'd191);
    rd(5'h04, d);
    chk("wrap_sticky", d, 32'd1);
    wr(5'h04, 32'h1);
    rd(5'h04, d);
    chk("wrap_w1c", d, 32'd0);

    // Duty extremes, then CLR latency
    wr(5'h11, 32'd0);
    wr(5'h12, 32'd255);
    wr(5'h00, 32'h6);
    repeat (300) @(negedge clk);
    bad0 = 0; bad1 = 0; bad2 = 0;
    repeat (300) begin
      @(negedge clk);
      if (out_port[0] !== 1'b0) bad0++;
      if (out_port[1] !== 1'b0) bad1++;
      if (out_port[2] !== 1'b1) bad2++;
    end
    chk("ch0_disabled_low", 32'(bad0), 32'd0);
    chk("ch1_duty0_low", 32'(bad1), 32'd0);
    chk("ch2_duty255_high", 32'(bad2), 32'd0);
    @(negedge clk);
    bus.address    = 5'h02;
    bus.writedata  = 32'h4;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    chk("clr_lag_still_high", 32'(out_port[2]), 32'd1);
    @(negedge clk);
    chk("clr_now_low", 32'(out_port[2]), 32'd0);
    rd(5'h00, d);
    chk("clr_outen", d, 32'h2);

    // Mid-period duty write is deferred to the next period
    wr(5'h00, 32'h1);
    wait_rise(0, "shadow", n);
    fork
      measure_run(0, 1'b1, h);
      begin
        repeat (10) @(negedge clk);
        wr(5'h10, 32'd128);
      end
    join
    chk("shadow_cur_high", 32'(h), 32'd64);
    measure_run(0, 1'b0, l);
    chk("shadow_cur_low", 32'(l), 32'd191);
    measure_run(0, 1'b1, h);
    chk("shadow_next_high", 32'(h), 32'd128);
    // Now at the negedge after cnt=128; the write below lands on the wrap edge.
    repeat (124) @(negedge clk);
    wr(5'h10, 32'd32);
    wait_rise(0, "wrapwr", n);
    measure_run(0, 1'b1, h);
    chk("wrap_cycle_write_high", 32'(h), 32'd32);

    // Prescaler 3 stretches the period to 1020 clocks
    wr(5'h10, 32'd64);
    wr(5'h03, 32'd3);
    wait_rise(0, "presc3", n);
    measure_run(0, 1'b1, h);
    chk("presc3_high", 32'(h), 32'd256);
    measure_run(0, 1'b0, l);
    chk("presc3_low", 32'(l), 32'd764);

    // Reset mid-period at cnt=100 with the output high
    wr(5'h03, 32'd0);
    wr(5'h10, 32'd200);
    wait_rise(0, "prereset", n);
    repeat (99) @(negedge clk);
    chk("pre_reset_high", 32'(out_port[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_out_zero", 32'(out_port), 32'd0);
    rd(5'h00, d); chk("reset_outen", d, 32'd0);
    rd(5'h03, d); chk("reset_presc", d, 32'd0);
    rd(5'h10, d); chk("reset_duty0", d, 32'd0);
    rd(5'h04, d); chk("reset_status", d, 32'd0);
    reset = 1'b0;
    fork
      wait_rise(0, "restart", n);
      begin
        wr(5'h10, 32'd64);
        wr(5'h00, 32'h1);
      end
    join
    chk("restart_first_rise", 32'(n), 32'd256);
    measure_run(0, 1'b1, h);
    chk("restart_high", 32'(h), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
